sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_acc_pkg.sv | 14 +
 rtl/sum_acc_add.sv | 35 +++
 rtl/sum_accumulator.sv | 119 +++++++++++
 tb/tb_sum_accumulator.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sum_acc_pkg.sv
// Package shared by the sum_accumulator block.
// Holds the batch FSM state encoding and the upstream sample width.
package sum_acc_pkg;

  // Upstream sample = {CARRY_OUT0, SUM1, SUM0}, range 0..7.
  localparam int unsigned SAMPLE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : sum_acc_pkg

// File: rtl/sum_acc_add.sv
// Accumulator adder: adds a zero-extended sample to the running total.
// Optional saturation is selected with macro SUM_ACC_SATURATE_EN:
//   defined   -> result clamps to all-ones when the add carries out
//   undefined -> result wraps modulo 2^ACC_W
// Ports:
//   acc_i    [ACC_W-1:0]    current total
//   sample_i [SAMPLE_W-1:0] sample to add
//   sum_o    [ACC_W-1:0]    new total (wrapped or clamped)
//   carry_o                 carry out of the ACC_W-bit addition
module sum_acc_add
  import sum_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 8
) (
  input  logic [ACC_W-1:0]    acc_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [ACC_W-1:0]    sum_o,
  output logic                carry_o
);

  logic [ACC_W:0] raw;

  always_comb begin
    raw     = {1'b0, acc_i} + {{(ACC_W + 1 - SAMPLE_W){1'b0}}, sample_i};
    carry_o = raw[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
    // Once clamped, any further non-zero sample carries again, so the
    // total stays pinned at all-ones for the rest of the batch.
    sum_o   = carry_o ? '1 : raw[ACC_W-1:0];
`else
    sum_o   = raw[ACC_W-1:0];
`endif
  end

endmodule : sum_acc_add

// File: rtl/sum_accumulator.sv
// Sums N_SAMPLES accepted 3-bit samples into an ACC_W-bit total, then
// presents the result with a valid/ready handshake.
// Build option: SUM_ACC_SATURATE_EN (see sum_acc_add) selects clamp vs wrap.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   SUM0, SUM1, CARRY_OUT0 upstream adder result forming the sample
//   IN_VALID / IN_READY   sample handshake
//   CLEAR                 synchronous abort, highest priority
//   TOTAL [ACC_W-1:0]     running sum
//   COUNT                 samples accepted in this batch
//   OUT_VALID / OUT_READY result handshake
//   OVERFLOW              sticky carry-out flag for this batch
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int unsigned ACC_W     = 8,
  parameter int unsigned N_SAMPLES = 4
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             SUM0,
  input  logic                             SUM1,
  input  logic                             CARRY_OUT0,
  input  logic                             IN_VALID,
  output logic                             IN_READY,
  input  logic                             CLEAR,
  output logic [ACC_W-1:0]                 TOTAL,
  output logic [$clog2(N_SAMPLES+1)-1:0]   COUNT,
  output logic                             OUT_VALID,
  input  logic                             OUT_READY,
  output logic                             OVERFLOW
);

  localparam int unsigned CNT_W = $clog2(N_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [SAMPLE_W-1:0] sample;
  logic [ACC_W-1:0]    add_sum;
  logic                add_carry;

  assign sample = {CARRY_OUT0, SUM1, SUM0};

  sum_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i    (total_q),
    .sample_i (sample),
    .sum_o    (add_sum),
    .carry_o  (add_carry)
  );

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (CLEAR) begin
      state_d = IDLE;
      total_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        // IDLE always holds zeroed registers, so it shares the ACCUM path;
        // with N_SAMPLES=1 the first accept lands directly in DONE.
        IDLE, ACCUM: begin
          if (IN_VALID) begin
            total_d = add_sum;
            count_d = count_q + CNT_W'(1);
            if (add_carry) ovf_d = 1'b1;
            state_d = (count_q == LAST_IDX) ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            state_d = IDLE;
            total_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          total_d = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      total_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs depend on state only.
  assign IN_READY  = (state_q != DONE);
  assign OUT_VALID = (state_q == DONE);
  assign TOTAL     = total_q;
  assign COUNT     = count_q;
  assign OVERFLOW  = ovf_q;

endmodule : sum_accumulator

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: an 8-bit/4-sample instance for the
// main flows and a 4-bit/4-sample instance for overflow behaviour.
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: ACC_W=8, N_SAMPLES=4
  logic       a_s0, a_s1, a_c, a_in_valid, a_in_ready, a_clear;
  logic [7:0] a_total;
  logic [2:0] a_count;
  logic       a_out_valid, a_out_ready, a_ovf;

  // Instance B: ACC_W=4, N_SAMPLES=4
  logic       b_s0, b_s1, b_c, b_in_valid, b_in_ready, b_clear;
  logic [3:0] b_total;
  logic [2:0] b_count;
  logic       b_out_valid, b_out_ready, b_ovf;

  int checks = 0;
  int errors = 0;

  sum_accumulator #(.ACC_W(8), .N_SAMPLES(4)) dut_a (
    .CLK(clk), .RST_N(rst_n), .SUM0(a_s0), .SUM1(a_s1), .CARRY_OUT0(a_c),
    .IN_VALID(a_in_valid), .IN_READY(a_in_ready), .CLEAR(a_clear),
    .TOTAL(a_total), .COUNT(a_count), .OUT_VALID(a_out_valid),
    .OUT_READY(a_out_ready), .OVERFLOW(a_ovf)
  );

  sum_accumulator #(.ACC_W(4), .N_SAMPLES(4)) dut_b (
    .CLK(clk), .RST_N(rst_n), .SUM0(b_s0), .SUM1(b_s1), .CARRY_OUT0(b_c),
    .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .CLEAR(b_clear),
    .TOTAL(b_total), .COUNT(b_count), .OUT_VALID(b_out_valid),
    .OUT_READY(b_out_ready), .OVERFLOW(b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_sample(input logic [2:0] v);
    {a_c, a_s1, a_s0} = v;
  endtask

  task automatic b_sample(input logic [2:0] v);
    {b_c, b_s1, b_s0} = v;
  endtask

  task automatic a_state(input string tag, input logic [31:0] tot, input logic [31:0] cnt,
                         input logic rdy, input logic vld, input logic ovf);
    check({tag, "_total"},     32'(a_total),     tot);
    check({tag, "_count"},     32'(a_count),     cnt);
    check({tag, "_in_ready"},  32'(a_in_ready),  32'(rdy));
    check({tag, "_out_valid"}, 32'(a_out_valid), 32'(vld));
    check({tag, "_overflow"},  32'(a_ovf),       32'(ovf));
  endtask

  initial begin
    rst_n = 1'b0;
    a_sample(3'd0); a_in_valid = 0; a_clear = 0; a_out_ready = 0;
    b_sample(3'd0); b_in_valid = 0; b_clear = 0; b_out_ready = 0;
    #2;
    a_state("reset", 0, 0, 1, 0, 0);
    check("reset_b_total", 32'(b_total), 0);
    #10 rst_n = 1'b1;

    // Batch 3,5,7,1 -> 3,8,15,16
    a_in_valid = 1; a_sample(3'd3); tick; a_state("b1_s1", 3, 1, 1, 0, 0);
    a_sample(3'd5); tick; a_state("b1_s2", 8, 2, 1, 0, 0);
    a_sample(3'd7); tick; a_state("b1_s3", 15, 3, 1, 0, 0);
    a_sample(3'd1); tick; a_state("b1_s4", 16, 4, 0, 1, 0);

    // DONE holds with samples offered and OUT_READY low
    a_sample(3'd7);
    for (int i = 0; i < 3; i++) begin
      tick; a_state("done_hold", 16, 4, 0, 1, 0);
    end
    a_in_valid = 0; a_out_ready = 1; tick;
    a_state("done_pop", 0, 0, 1, 0, 0);
    a_out_ready = 0;

    // CLEAR beats a simultaneous sample
    a_in_valid = 1; a_sample(3'd2); tick;
    a_sample(3'd3); tick; a_state("pre_clr", 5, 2, 1, 0, 0);
    a_sample(3'd6); a_clear = 1; tick;
    a_state("clr", 0, 0, 1, 0, 0);
    a_clear = 0; a_in_valid = 0; tick;
    a_state("clr_idle", 0, 0, 1, 0, 0);

    // Asynchronous reset mid-batch, then a fresh batch of ones
    a_in_valid = 1; a_sample(3'd1); tick; tick;
    a_state("pre_rst", 2, 2, 1, 0, 0);
    a_in_valid = 0;
    #2 rst_n = 1'b0;
    #1 a_state("async_rst", 0, 0, 1, 0, 0);
    #1 rst_n = 1'b1;
    a_in_valid = 1;
    for (int i = 0; i < 4; i++) tick;
    a_state("ones", 4, 4, 0, 1, 0);
    a_in_valid = 0; a_out_ready = 1; tick; a_out_ready = 0;
    a_state("ones_pop", 0, 0, 1, 0, 0);

    // IN_VALID toggling with sample 2: only valid cycles count
    a_sample(3'd2);
    for (int i = 0; i < 8; i++) begin
      a_in_valid = (i % 2 == 0);
      tick;
    end
    a_in_valid = 0;
    a_state("toggle", 8, 4, 0, 1, 0);

    // CLEAR takes priority over OUT_READY in DONE
    a_clear = 1; a_out_ready = 1; tick;
    a_clear = 0; a_out_ready = 0;
    a_state("clr_done", 0, 0, 1, 0, 0);

    // 4-bit instance: 7,7,7,7 overflows on the third sample
    b_in_valid = 1; b_sample(3'd7);
    tick; check("ovf_s1_total", 32'(b_total), 7);
    tick; check("ovf_s2_total", 32'(b_total), 14);
    check("ovf_s2_flag", 32'(b_ovf), 0);
    tick; check("ovf_s3_flag", 32'(b_ovf), 1);
`ifdef SUM_ACC_SATURATE_EN
    check("ovf_s3_total", 32'(b_total), 15);
`else
    check("ovf_s3_total", 32'(b_total), 5);
`endif
    tick; b_in_valid = 0;
`ifdef SUM_ACC_SATURATE_EN
    check("ovf_final_total", 32'(b_total), 15);
`else
    check("ovf_final_total", 32'(b_total), 12);
`endif
    check("ovf_final_flag", 32'(b_ovf), 1);
    check("ovf_final_valid", 32'(b_out_valid), 1);
    b_out_ready = 1; tick; b_out_ready = 0;
    check("ovf_pop_flag", 32'(b_ovf), 0);
    check("ovf_pop_total", 32'(b_total), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sum_accumulator
